// File: rtl/cpu_types_pkg.sv
// Shared types for the 5-stage core: datapath words, register indices,
// writeback source select and the data-memory access state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbit_t;

  typedef enum logic [1:0] {
    SEL_ALU = 2'd0,
    SEL_MEM = 2'd1,
    SEL_NPC = 2'd2,
    SEL_LUI = 2'd3
  } regsel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } memstate_t;

  // LUI arrives already shifted from the ALU, so it shares the ALU path.
  function automatic word_t wb_select(input regsel_t sel, input word_t alu,
                                      input word_t mem, input word_t npc);
    case (sel)
      SEL_MEM: return mem;
      SEL_NPC: return npc;
      default: return alu;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_fsm.sv
// Data-cache request sequencer: issues the gated request, stalls until dhit
// and parks load data in hold_q when the front end is not ready to advance.
module dmem_access_fsm
  import cpu_types_pkg::*;
(
  input  logic      CLK,
  input  logic      nRST,
  input  logic      i_ihit,
  input  logic      i_dhit,
  input  logic      i_valid,
  input  logic      i_mem_ren,
  input  logic      i_mem_wen,
  input  logic      i_halt,
  input  word_t     i_dmemload,
  output logic      o_dmem_ren,
  output logic      o_dmem_wen,
  output logic      o_mem_stall,
  output memstate_t o_state,
  output word_t     o_hold
);

  memstate_t r_state;
  memstate_t w_next;
  word_t     r_hold;
  logic      w_capture;
  logic      w_req;
  logic      w_issue;

  assign w_req = (i_mem_ren | i_mem_wen) & i_valid & ~i_halt;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req && !i_dhit) begin
          w_next = ACCESS;
        end else if (w_req && i_dhit && !i_ihit) begin
          w_next    = DONE;
          w_capture = 1'b1;
        end
      end
      ACCESS: begin
        if (i_dhit) begin
          if (i_ihit) begin
            w_next = IDLE;
          end else begin
            w_next    = DONE;
            w_capture = 1'b1;
          end
        end
      end
      DONE: begin
        if (i_ihit) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (i_halt) begin
      w_next    = IDLE;
      w_capture = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: state is non-blocking so every register samples pre-edge values.
    if (!nRST) begin
      r_state <= IDLE;
      r_hold  <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture) r_hold <= i_dmemload;
    end
  end

  // Requests are masked in DONE so a completed access is never reissued,
  // and masked by nRST so a reset mid-access drops the request at once.
  assign w_issue     = nRST & i_valid & ~i_halt & (r_state != DONE);
  assign o_dmem_ren  = w_issue & i_mem_ren;
  assign o_dmem_wen  = w_issue & i_mem_wen;
  assign o_mem_stall = nRST & w_req & ~i_dhit & (r_state != DONE);
  assign o_state     = r_state;
  assign o_hold      = r_hold;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: data-cache sequencing plus the writeback register, sticky
// halt and retired-instruction counter.
module mem_wb_stage
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             flush,
  input  logic             valid_in,
  input  logic             memREN_in,
  input  logic             memWEN_in,
  input  logic             halt_in,
  input  word_t            nPC_in,
  input  logic             regWr_in,
  input  regsel_t          regSel_in,
  input  regbit_t          regDst_in,
  input  word_t            ALUOut_in,
  input  word_t            dmemload_in,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             mem_stall,
  output logic             wb_en,
  output regbit_t          wb_dst,
  output word_t            wb_data,
  output logic             halt,
  output logic [CNT_W-1:0] retired
);

  memstate_t        w_state;
  word_t            w_hold;
  word_t            w_mem_data;
  word_t            w_wb_data;
  logic             w_advance;
  logic             r_wb_en;
  regbit_t          r_wb_dst;
  word_t            r_wb_data;
  logic             r_halt;
  logic [CNT_W-1:0] r_retired;

  dmem_access_fsm u_fsm (
    .CLK         (CLK),
    .nRST        (nRST),
    .i_ihit      (ihit),
    .i_dhit      (dhit),
    .i_valid     (valid_in),
    .i_mem_ren   (memREN_in),
    .i_mem_wen   (memWEN_in),
    .i_halt      (r_halt),
    .i_dmemload  (dmemload_in),
    .o_dmem_ren  (dmemREN),
    .o_dmem_wen  (dmemWEN),
    .o_mem_stall (mem_stall),
    .o_state     (w_state),
    .o_hold      (w_hold)
  );

  assign w_advance  = ihit & ~mem_stall & ~r_halt;
  assign w_mem_data = (w_state == DONE) ? w_hold : dmemload_in;
  assign w_wb_data  = wb_select(regSel_in, ALUOut_in, w_mem_data, nPC_in);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wb_en   <= 1'b0;
      r_wb_dst  <= '0;
      r_wb_data <= '0;
      r_halt    <= 1'b0;
      r_retired <= '0;
    end else if (r_halt) begin
      r_wb_en <= 1'b0;
    end else if (w_advance) begin
      if (flush) begin
        r_wb_en   <= 1'b0;
        r_wb_dst  <= '0;
        r_wb_data <= '0;
      end else begin
        // $0 is hardwired: never raise the write enable for it.
        r_wb_en   <= regWr_in & valid_in & (regDst_in != '0);
        r_wb_dst  <= regDst_in;
        r_wb_data <= w_wb_data;
        r_retired <= r_retired + CNT_W'(valid_in);
        r_halt    <= halt_in & valid_in;
      end
    end
  end

  assign wb_en   = r_wb_en;
  assign wb_dst  = r_wb_dst;
  assign wb_data = r_wb_data;
  assign halt    = r_halt;
  assign retired = r_retired;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a behavioural model tracks whether load
// data has already returned, and every negedge compares the DUT against it.
module tb_mem_wb_stage;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, flush, valid_in, memREN_in, memWEN_in, halt_in;
  word_t       nPC_in, ALUOut_in, dmemload_in;
  logic        regWr_in;
  regsel_t     regSel_in;
  regbit_t     regDst_in;
  logic        dmemREN, dmemWEN, mem_stall, wb_en, halt;
  regbit_t     wb_dst;
  word_t       wb_data;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  mem_wb_stage #(.CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .flush(flush),
    .valid_in(valid_in), .memREN_in(memREN_in), .memWEN_in(memWEN_in),
    .halt_in(halt_in), .nPC_in(nPC_in), .regWr_in(regWr_in),
    .regSel_in(regSel_in), .regDst_in(regDst_in), .ALUOut_in(ALUOut_in),
    .dmemload_in(dmemload_in), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .mem_stall(mem_stall), .wb_en(wb_en), .wb_dst(wb_dst),
    .wb_data(wb_data), .halt(halt), .retired(retired)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_done means "this memory op's data has already come back".
  logic        m_done, m_halt, m_wb_en;
  word_t       m_hold, m_wb_data, m_mux;
  regbit_t     m_wb_dst;
  logic [31:0] m_retired;
  logic        m_req, m_stall, m_adv;

  assign m_req   = (memREN_in | memWEN_in) & valid_in & ~m_halt;
  assign m_stall = m_req & ~dhit & ~m_done;
  assign m_adv   = ihit & ~m_stall & ~m_halt;
  assign m_mux   = (regSel_in == SEL_NPC) ? nPC_in :
                   (regSel_in == SEL_MEM) ? (m_done ? m_hold : dmemload_in) : ALUOut_in;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_done <= 1'b0; m_hold <= '0; m_halt <= 1'b0; m_wb_en <= 1'b0;
      m_wb_dst <= '0; m_wb_data <= '0; m_retired <= '0;
    end else if (m_halt) begin
      m_wb_en <= 1'b0;
      m_done  <= 1'b0;
    end else if (m_adv) begin
      m_done <= 1'b0;
      if (flush) begin
        m_wb_en <= 1'b0; m_wb_dst <= '0; m_wb_data <= '0;
      end else begin
        m_wb_en   <= regWr_in && valid_in && (regDst_in != 5'd0);
        m_wb_dst  <= regDst_in;
        m_wb_data <= m_mux;
        m_retired <= m_retired + 32'(valid_in);
        m_halt    <= halt_in && valid_in;
      end
    end else if (m_req && dhit && !m_done) begin
      m_done <= 1'b1;
      m_hold <= dmemload_in;
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (nRST) begin
        check("cmp_dmemREN", dmemREN, memREN_in & valid_in & ~m_halt & ~m_done);
        check("cmp_dmemWEN", dmemWEN, memWEN_in & valid_in & ~m_halt & ~m_done);
        check("cmp_mem_stall", mem_stall, m_stall);
        check("cmp_wb_en", wb_en, m_wb_en);
        check("cmp_wb_dst", wb_dst, m_wb_dst);
        check("cmp_wb_data", wb_data, m_wb_data);
        check("cmp_halt", halt, m_halt);
        check("cmp_retired", retired, m_retired);
      end
    end
  end

  task automatic idle();
    valid_in = 0; memREN_in = 0; memWEN_in = 0; halt_in = 0; regWr_in = 0;
    regSel_in = SEL_ALU; regDst_in = '0; ALUOut_in = '0; nPC_in = '0;
    dmemload_in = '0; flush = 0; dhit = 0; ihit = 1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input regbit_t dst, input logic fl);
    idle();
    valid_in = 1; memREN_in = 1; regWr_in = 1; regSel_in = SEL_MEM;
    regDst_in = dst; flush = fl;
  endtask

  int stall_cnt;

  initial begin
    nRST = 0;
    idle();
    valid_in = 1; memREN_in = 1;
    #3;
    check("reset_dmemREN", dmemREN, 0);
    check("reset_stall", mem_stall, 0);
    check("reset_wb", {wb_en, halt, wb_dst, wb_data[24:0]}, 0);
    check("reset_retired", retired, 0);
    idle();
    #9 nRST = 1;
    tick();

    // ALU writeback
    valid_in = 1; regWr_in = 1; regSel_in = SEL_ALU; ALUOut_in = 32'h0000_1234; regDst_in = 5;
    tick();
    check("alu_wb_en", wb_en, 1);
    check("alu_wb_dst", wb_dst, 5);
    check("alu_wb_data", wb_data, 32'h0000_1234);
    check("alu_retired", retired, 1);

    // Load with a 3-cycle miss
    load(7, 0);
    stall_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1 if (mem_stall) stall_cnt++;
      tick();
    end
    dhit = 1; dmemload_in = 32'hDEAD_BEEF;
    #1 if (mem_stall) stall_cnt++;
    tick();
    check("miss_stall_cycles", stall_cnt, 3);
    check("miss_wb_data", wb_data, 32'hDEAD_BEEF);
    check("miss_wb_dst", wb_dst, 7);
    check("miss_retired", retired, 2);

    // dhit while the front end is not ready
    load(8, 0);
    dhit = 1; dmemload_in = 32'hCAFE_0001; ihit = 0;
    tick();
    check("done_dmemREN", dmemREN, 0);
    dhit = 0; dmemload_in = 32'h0;
    #1 check("done_no_stall", mem_stall, 0);
    tick();
    tick();
    check("done_wb_held", wb_data, 32'hDEAD_BEEF);
    ihit = 1;
    tick();
    check("done_wb_data", wb_data, 32'hCAFE_0001);
    check("done_retired", retired, 3);

    // Flush on an advancing register write
    idle();
    valid_in = 1; regWr_in = 1; ALUOut_in = 32'h55; regDst_in = 9; flush = 1;
    tick();
    check("flush_wb_en", wb_en, 0);
    check("flush_wb_data", wb_data, 0);
    check("flush_retired", retired, 3);

    // Write to $0 retires but does not write
    flush = 0; regDst_in = 0; ALUOut_in = 32'h77;
    tick();
    check("r0_wb_en", wb_en, 0);
    check("r0_retired", retired, 4);

    // JAL link value
    idle();
    valid_in = 1; regWr_in = 1; regSel_in = SEL_NPC; nPC_in = 32'h0000_0044;
    ALUOut_in = 32'h999; regDst_in = 31;
    tick();
    check("jal_wb_data", wb_data, 32'h0000_0044);
    check("jal_wb_dst", wb_dst, 31);
    check("jal_retired", retired, 5);

    // Flush held during a miss: stall wins, bubble on release
    load(10, 1);
    #1 check("flush_miss_stall0", mem_stall, 1);
    tick();
    check("flush_miss_stall1", mem_stall, 1);
    dhit = 1; dmemload_in = 32'h1111;
    tick();
    check("flush_miss_wb_en", wb_en, 0);
    check("flush_miss_retired", retired, 5);

    // HALT carried by a store: the store completes first
    idle();
    valid_in = 1; memWEN_in = 1; halt_in = 1;
    #1 check("halt_store_wen", dmemWEN, 1);
    check("halt_store_stall", mem_stall, 1);
    tick();
    check("halt_not_yet", halt, 0);
    dhit = 1;
    tick();
    check("halt_set", halt, 1);
    check("halt_retired", retired, 6);
    load(3, 0);
    #1 check("halt_no_ren", dmemREN, 0);
    check("halt_no_stall", mem_stall, 0);
    tick();
    tick();
    check("halt_frozen", retired, 6);
    check("halt_wb_en", wb_en, 0);
    check("halt_sticky", halt, 1);

    // Reset in the middle of an access
    nRST = 0;
    idle();
    #3 nRST = 1;
    tick();
    load(4, 0);
    tick();
    #2 nRST = 0;
    #1;
    check("rst_mid_ren", dmemREN, 0);
    check("rst_mid_stall", mem_stall, 0);
    check("rst_mid_wb", {wb_en, halt, wb_dst, wb_data[24:0]}, 0);
    check("rst_mid_retired", retired, 0);
    idle();
    #3 nRST = 1;
    tick();

    // Load hitting at once: no stall cycle
    load(6, 0);
    dhit = 1; dmemload_in = 32'h0BAD_F00D;
    #1 check("hit_no_stall", mem_stall, 0);
    tick();
    check("hit_wb_data", wb_data, 32'h0BAD_F00D);
    check("hit_retired", retired, 1);

    // LUI shares the ALU path
    idle();
    valid_in = 1; regWr_in = 1; regSel_in = SEL_LUI; ALUOut_in = 32'hABCD_0000; regDst_in = 2;
    tick();
    check("lui_wb_data", wb_data, 32'hABCD_0000);
    idle();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access controller plus MEM/WB pipeline register for the 5-stage core. It consumes the memory-stage outputs (nPC, regWr, regSel, regDst, ALUOut, dmemload), sequences the data-cache request until dhit, holds load data if the front end is not ready, and latches the selected writeback value. It drives the register-file write port, the forwarding bus and the halt/retire status.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- CLK  in  1  clock; everything samples rising edge
- nRST  in  1  asynchronous, active-low reset
- ihit  in  1  instruction side ready; pipeline may advance
- dhit  in  1  data cache completed current request
- flush  in  1  squash the instruction entering WB
- valid_in  in  1  memory-stage slot holds a real instruction
- memREN_in, memWEN_in  in  1 each  instruction needs load / store
- halt_in  in  1  instruction is HALT
- nPC_in  in  word_t  PC+4 / link address
- regWr_in  in  1  instruction writes a register
- regSel_in  in  regsel_t  writeback source
- regDst_in  in  regbit_t  destination register
- ALUOut_in  in  word_t  ALU result / data address
- dmemload_in  in  word_t  data returned by cache
- dmemREN, dmemWEN  out  1 each  gated cache request
- mem_stall  out  1  hold all upstream latches this cycle
- wb_en  out  1  register-file write enable
- wb_dst  out  regbit_t  register-file write address
- wb_data  out  word_t  register-file write data (also forwarding value)
- halt  out  1  sticky halt
- retired  out  CNT_W  count of valid instructions that entered WB

## Operation
- Access FSM, states IDLE, ACCESS, DONE; reset to IDLE.
- req = (memREN_in | memWEN_in) & valid_in & ~halt.
- IDLE: if req & ~dhit -> ACCESS. If req & dhit & ~ihit -> DONE, capture dmemload_in into hold_q. Otherwise stay.
- ACCESS: dhit & ihit -> IDLE. dhit & ~ihit -> DONE, capture hold_q. ~dhit -> stay.
- DONE: ihit -> IDLE. Otherwise stay.
- dmemREN/dmemWEN = memREN_in/memWEN_in & valid_in & ~halt, only in IDLE or ACCESS. Forced 0 in DONE so an access is never issued twice.
- mem_stall = req & ~dhit & (state != DONE). Stores also stall until dhit.
- advance = ihit & ~mem_stall & ~halt.
- Writeback data mux by regSel_in:
  - SEL_ALU: ALUOut_in
  - SEL_MEM: hold_q if state == DONE, else dmemload_in
  - SEL_NPC: nPC_in
  - SEL_LUI: ALUOut_in
- On advance:
  - flush=1: bubble. wb_en=0, wb_dst=0, wb_data=0; counter unchanged; halt not captured.
  - flush=0:
    - wb_en = regWr_in & valid_in & (regDst_in != 0)
    - wb_dst = regDst_in
    - wb_data = mux result
    - retired += valid_in
    - halt set if halt_in & valid_in
- No advance: WB register holds its value. wb_en is held, so the rewrite is idempotent.
- Once halt=1:
  - wb_en cleared next cycle, then stays 0.
  - FSM forced to IDLE; no cache requests.
  - retired frozen; only nRST clears it.
- retired wraps modulo 2^CNT_W.
- Register 0 is never written. Enforced here as well as in the register file.

## Timing
- Reset values (async, nRST low): state IDLE, hold_q 0, wb_en 0, wb_dst 0, wb_data 0, halt 0, retired 0. Combinational outputs dmemREN, dmemWEN and mem_stall are 0 while nRST is low.
- WB outputs are registered, 1 cycle after the advancing edge.
- A load hitting in the same cycle it is presented costs 0 stall cycles.
- A miss adds N stall cycles for N cycles without dhit.
- flush and mem_stall together: mem_stall wins. The flush is applied on the cycle the stall releases; upstream holds flush asserted.
- ihit without dhit on a memory op: no advance, stays in IDLE/ACCESS.
- halt_in arriving with a pending store: the store completes (dhit) before halt latches.
- Reset mid-ACCESS: the request drops immediately and the FSM returns to IDLE with no capture.

## Structure
- In cpu_types_pkg:
  - regsel_t, a 2-bit enum SEL_ALU=0, SEL_MEM=1, SEL_NPC=2, SEL_LUI=3
  - word_t (32 b) and regbit_t (5 b), existing
  - typedef memstate_t {IDLE, ACCESS, DONE}
- One natural sub-module: dmem_access_fsm. It owns state, hold_q, dmemREN/dmemWEN and mem_stall.
- mem_wb_stage instantiates it and adds the WB register, the mux, halt and the counter.

## Test plan
- ALU writeback: regSel=SEL_ALU, ALUOut=0x0000_1234, regDst=5, ihit=1 -> next cycle wb_en=1, wb_dst=5, wb_data=0x0000_1234, retired=1.
- Load with 3-cycle miss: memREN=1, dhit low 3 cycles then high with dmemload=0xDEAD_BEEF -> mem_stall=1 for exactly 3 cycles; wb_data=0xDEAD_BEEF one cycle after dhit.
- dhit without ihit:
  - dhit=1 with dmemload=0xCAFE_0001 while ihit=0 -> state DONE, dmemREN=0.
  - Drive dmemload=0 and raise ihit 2 cycles later -> wb_data=0xCAFE_0001.
- Flush plus $0 guard:
  - flush=1 on an advancing regWr instruction -> wb_en=0, retired unchanged.
  - regDst=0, regWr=1 -> wb_en=0 but retired increments.
- JAL link: regSel=SEL_NPC, nPC=0x0000_0044, regDst=31 -> wb_data=0x0000_0044, wb_dst=31.
- Halt and reset:
  - halt_in with valid_in -> halt=1 sticky; further memREN_in produces dmemREN=0 and retired frozen.
  - nRST low mid-ACCESS -> dmemREN=0 asynchronously, all outputs 0.
